// File: rtl/pic_bus_ctrl_pkg.sv
// Shared types and constants for the PIC bus-control slice.
package pic_pkg;

  // Initialisation / operation state of the command decoder
  typedef enum logic [2:0] {
    ST_ICW1  = 3'd0,
    ST_ICW2  = 3'd1,
    ST_ICW3  = 3'd2,
    ST_ICW4  = 3'd3,
    ST_READY = 3'd4
  } pic_state_t;

  // Command-byte bit positions
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ID   = 4;
  localparam int OCW_SEL3  = 3;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;

  // Read-select encoding for the a0=0 read path
  localparam logic RSEL_IRR = 1'b0;
  localparam logic RSEL_ISR = 1'b1;

endpackage

// File: rtl/pic_bus_ctrl_sync.sv
// Synchroniser for the CPU bus pins, with a one-cycle-older copy of every
// synchronised signal so the decoder can see edges and pre-edge values.
module pic_bus_sync #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_n_i,
  input  logic          rd_n_i,
  input  logic          wr_n_i,
  input  logic          a0_i,
  input  logic [DW-1:0] din_i,
  output logic          cs_s_o,
  output logic          rd_s_o,
  output logic          wr_s_o,
  output logic          a0_s_o,
  output logic          cs_p_o,
  output logic          rd_p_o,
  output logic          wr_p_o,
  output logic          a0_p_o,
  output logic [DW-1:0] din_p_o,
  output logic          wr_rise_o
);

  localparam int W = DW + 4;
  // Idle bus: strobes and chip select high, address/data low
  localparam logic [W-1:0] IDLE = {3'b111, {(DW + 1){1'b0}}};

  logic [W-1:0] stg_q [SYNC_STAGES];
  logic [W-1:0] prev_q;

  // Shift the packed pin vector through the sync chain and keep one older copy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg_q[i] <= IDLE;
      prev_q <= IDLE;
    end else begin
      stg_q[0] <= {cs_n_i, rd_n_i, wr_n_i, a0_i, din_i};
      for (int i = 1; i < SYNC_STAGES; i++) stg_q[i] <= stg_q[i-1];
      prev_q <= stg_q[SYNC_STAGES-1];
    end
  end

  assign cs_s_o    = stg_q[SYNC_STAGES-1][W-1];
  assign rd_s_o    = stg_q[SYNC_STAGES-1][W-2];
  assign wr_s_o    = stg_q[SYNC_STAGES-1][W-3];
  assign a0_s_o    = stg_q[SYNC_STAGES-1][DW];
  assign cs_p_o    = prev_q[W-1];
  assign rd_p_o    = prev_q[W-2];
  assign wr_p_o    = prev_q[W-3];
  assign a0_p_o    = prev_q[DW];
  assign din_p_o   = prev_q[DW-1:0];
  assign wr_rise_o = wr_s_o & ~wr_p_o;

endmodule

// File: rtl/pic_bus_ctrl.sv
// PIC data-bus buffer and read/write control: ICW/OCW decode and read-back.
module pic_bus_ctrl
  import pic_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic          a0,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_oe,
  input  logic [7:0]    irr,
  input  logic [7:0]    isr,
  output logic [7:0]    imr,
  output logic [7:0]    icw1_q,
  output logic [7:0]    icw2_q,
  output logic [7:0]    icw3_q,
  output logic [7:0]    icw4_q,
  output logic          init_done,
  output logic          ocw2_stb,
  output logic [7:0]    ocw2_q,
  output logic          poll_stb,
  output logic          bus_err
);

  logic          cs_s, rd_s, wr_s, a0_s;
  logic          cs_p, rd_p, wr_p, a0_p;
  logic [DW-1:0] din_p;
  logic          wr_rise;

  pic_bus_sync #(.DW(DW), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst),
    .cs_n_i(cs_n), .rd_n_i(rd_n), .wr_n_i(wr_n), .a0_i(a0), .din_i(din),
    .cs_s_o(cs_s), .rd_s_o(rd_s), .wr_s_o(wr_s), .a0_s_o(a0_s),
    .cs_p_o(cs_p), .rd_p_o(rd_p), .wr_p_o(wr_p), .a0_p_o(a0_p),
    .din_p_o(din_p), .wr_rise_o(wr_rise)
  );

  pic_state_t    state_q;
  logic [7:0]    imr_q;
  logic          rsel_q;
  logic          cmt_q;
  logic          cmd_a0_q;
  logic [7:0]    cmd_d_q;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] dout_d;
  logic [7:0]    rd_sel_d;
  logic          oe_d;
  logic          dout_oe_q;
  logic          bus_err_q;
  logic          ocw2_stb_q;
  logic          poll_stb_q;

  // Latch a commit on the rising write strobe using the pre-edge bus values
  always_ff @(posedge clk) begin
    if (rst) begin
      cmt_q    <= 1'b0;
      cmd_a0_q <= 1'b0;
      cmd_d_q  <= 8'h00;
    end else begin
      cmt_q    <= wr_rise & ~cs_p & rd_p;
      cmd_a0_q <= a0_p;
      cmd_d_q  <= din_p[7:0];
    end
  end

  // Command decoder: ICW sequence, OCW handling and one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ICW1;
      imr_q      <= 8'hFF;
      icw1_q     <= 8'h00;
      icw2_q     <= 8'h00;
      icw3_q     <= 8'h00;
      icw4_q     <= 8'h00;
      ocw2_q     <= 8'h00;
      rsel_q     <= RSEL_IRR;
      ocw2_stb_q <= 1'b0;
      poll_stb_q <= 1'b0;
    end else begin
      ocw2_stb_q <= 1'b0;
      poll_stb_q <= 1'b0;
      if (cmt_q) begin
        if (!cmd_a0_q && cmd_d_q[ICW1_ID]) begin
          // ICW1 restarts the sequence from any state
          icw1_q  <= cmd_d_q;
          imr_q   <= 8'h00;
          icw3_q  <= 8'h00;
          icw4_q  <= 8'h00;
          rsel_q  <= RSEL_IRR;
          state_q <= ST_ICW2;
        end else begin
          case (state_q)
            ST_ICW2: begin
              if (cmd_a0_q) begin
                icw2_q <= cmd_d_q;
                if (!icw1_q[ICW1_SNGL])    state_q <= ST_ICW3;
                else if (icw1_q[ICW1_IC4]) state_q <= ST_ICW4;
                else                       state_q <= ST_READY;
              end
            end
            ST_ICW3: begin
              if (cmd_a0_q) begin
                icw3_q  <= cmd_d_q;
                state_q <= icw1_q[ICW1_IC4] ? ST_ICW4 : ST_READY;
              end
            end
            ST_ICW4: begin
              if (cmd_a0_q) begin
                icw4_q  <= cmd_d_q;
                state_q <= ST_READY;
              end
            end
            ST_READY: begin
              if (cmd_a0_q) begin
                imr_q <= cmd_d_q;
              end else if (!cmd_d_q[OCW_SEL3]) begin
                ocw2_q     <= cmd_d_q;
                ocw2_stb_q <= 1'b1;
              end else begin
                if (cmd_d_q[OCW3_RR]) rsel_q <= cmd_d_q[OCW3_RIS];
                if (cmd_d_q[OCW3_P])  poll_stb_q <= 1'b1;
              end
            end
            default: begin
              // ST_ICW1 accepts nothing but ICW1
            end
          endcase
        end
      end
    end
  end

  // Read-back mux, zero-extended and forced to zero while not driving
  always_comb begin
    oe_d     = ~cs_s & ~rd_s & wr_s;
    rd_sel_d = 8'h00;
    dout_d   = '0;
    if (a0_s)                     rd_sel_d = imr_q;
    else if (rsel_q == RSEL_ISR)  rd_sel_d = isr;
    else                          rd_sel_d = irr;
    if (oe_d) dout_d[7:0] = rd_sel_d;
    else      dout_d[7:0] = 8'h00;
  end

  // Register the read data, drive enable and contention pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      dout_oe_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      dout_oe_q <= oe_d;
      bus_err_q <= (~cs_s & ~rd_s & ~wr_s) & ~(~cs_p & ~rd_p & ~wr_p);
    end
  end

  assign dout      = dout_q;
  assign dout_oe   = dout_oe_q;
  assign imr       = imr_q;
  assign init_done = (state_q == ST_READY);
  assign ocw2_stb  = ocw2_stb_q;
  assign poll_stb  = poll_stb_q;
  assign bus_err   = bus_err_q;

endmodule
